// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: SLC-3 CPU memory controller with fixed-latency RAM reads,
// single-cycle RAM writes and a switch/hex-display I/O location at 0xFFFF.
module slc3_mem_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Rd,
    input  logic        Req_Wr,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [9:0]  SW,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic        Busy,
    output logic [15:0] RAM_addr,
    output logic [15:0] RAM_wdata,
    output logic        RAM_re,
    output logic        RAM_we,
    input  logic [15:0] RAM_rdata,
    output logic [15:0] Hex_Data,
    output logic [15:0] Access_Count
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, WR, IO, DONE} state_t;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic [15:0] data_q, data_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] access_count_q, access_count_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        re_q, re_d;
    logic        we_q, we_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        data_d         = data_q;
        hex_d          = hex_q;
        access_count_d = access_count_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        ready_d        = 1'b0;
        re_d           = 1'b0;
        we_d           = 1'b0;
        case (state_q)
            IDLE: begin
                // A read wins when both requests are high; the write data is not latched.
                if (Req_Rd || Req_Wr) begin
                    addr_d  = ADDR;
                    rd_d    = Req_Rd;
                    wdata_d = Req_Rd ? wdata_q : Data_from_CPU;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (ADDR == IO_ADDR) ? IO : Req_Rd ? RD_WAIT : WR;
                    re_d    = Req_Rd && (ADDR != IO_ADDR);
                    we_d    = !Req_Rd && (ADDR != IO_ADDR);
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                re_d  = (cnt_q != 4'd1);
                if (cnt_q == 4'd1) begin
                    data_d         = RAM_rdata;
                    state_d        = DONE;
                    ready_d        = 1'b1;
                    access_count_d = access_count_q + 16'd1;
                end
            end
            WR: begin
                state_d        = DONE;
                ready_d        = 1'b1;
                access_count_d = access_count_q + 16'd1;
            end
            IO: begin
                data_d         = rd_q ? {6'b0, SW} : data_q;
                hex_d          = rd_q ? hex_q : wdata_q;
                state_d        = DONE;
                ready_d        = 1'b1;
                access_count_d = access_count_q + 16'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_q           <= 1'b0;
            data_q         <= '0;
            hex_q          <= '0;
            access_count_q <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            re_q           <= 1'b0;
            we_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            hex_q          <= hex_d;
            access_count_q <= access_count_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            re_q           <= re_d;
            we_q           <= we_d;
        end
    end

    assign Data_to_CPU  = data_q;
    assign Ready        = ready_q;
    assign Busy         = busy_q;
    assign RAM_addr     = addr_q;
    assign RAM_wdata    = wdata_q;
    assign RAM_re       = re_q;
    assign RAM_we       = we_q;
    assign Hex_Data     = hex_q;
    assign Access_Count = access_count_q;
endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// tb_slc3_mem_ctrl: randomized scoreboard bench for slc3_mem_ctrl with a
// fixed-latency RAM model and an array-based reference memory.
module tb_slc3_mem_ctrl;
    localparam int W = 2;

    logic        Clk = 1'b0, Reset = 1'b1, Req_Rd = 1'b0, Req_Wr = 1'b0;
    logic [15:0] ADDR = '0, Data_from_CPU = '0, RAM_rdata;
    logic [9:0]  SW = '0;
    logic [15:0] Data_to_CPU, RAM_addr, RAM_wdata, Hex_Data, Access_Count;
    logic        Ready, Busy, RAM_re, RAM_we;

    always #5 Clk = ~Clk;

    slc3_mem_ctrl #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .SW(SW), .Data_to_CPU(Data_to_CPU), .Ready(Ready),
        .Busy(Busy), .RAM_addr(RAM_addr), .RAM_wdata(RAM_wdata), .RAM_re(RAM_re),
        .RAM_we(RAM_we), .RAM_rdata(RAM_rdata), .Hex_Data(Hex_Data), .Access_Count(Access_Count)
    );

    typedef struct {
        logic [15:0] data, hex, count, addr, wdata;
        int re_n, we_n, due;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int checks = 0, failures = 0, cyc = 0, re_seen = 0, we_seen = 0, re_run = 0;
    logic [15:0] ram [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] m_data = '0, m_hex = '0, m_count = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    // RAM data is only valid on the W-th consecutive cycle of RAM_re.
    always @(posedge Clk) begin
        if (RAM_we) ram[RAM_addr] <= RAM_wdata;
        re_run <= RAM_re ? re_run + 1 : 0;
    end
    assign RAM_rdata = (RAM_re && re_run == W - 1) ? ram[RAM_addr] : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("re_we_exclusive", 32'(RAM_re & RAM_we), 0);
            re_seen += int'(RAM_re);
            we_seen += int'(RAM_we);
            if (RAM_we && q.size() > 0) begin
                chk("we_wdata", 32'(RAM_wdata), 32'(q[0].wdata));
                chk("we_addr", 32'(RAM_addr), 32'(q[0].addr));
                chk("we_cycle", 32'(cyc), 32'(q[0].due - 1));
            end
            if (Ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_ready: Ready=1 with no access outstanding (t=%0t)", $time);
                end else begin
                    got = q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(got.due));
                    chk("data_to_cpu", 32'(Data_to_CPU), 32'(got.data));
                    chk("hex_data", 32'(Hex_Data), 32'(got.hex));
                    chk("access_count", 32'(Access_Count), 32'(got.count));
                    chk("ram_addr", 32'(RAM_addr), 32'(got.addr));
                    chk("re_cycles", 32'(re_seen), 32'(got.re_n));
                    chk("we_cycles", 32'(we_seen), 32'(got.we_n));
                    chk("busy_in_done", 32'(Busy), 1);
                end
                re_seen = 0;
                we_seen = 0;
            end
        end
    end

    // Issues one request and holds it across `reps` back-to-back accesses.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] d, input logic [9:0] sw, input int reps);
        int t = 0;
        int n, lat;
        bit ram_acc;
        exp_t e;
        @(negedge Clk);
        while (Busy && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (Busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: Busy=1 after 100 cycles, required 0");
            return;
        end
        Req_Rd = rd; Req_Wr = wr; ADDR = a; Data_from_CPU = d; SW = sw;
        @(posedge Clk);
        #1;
        n = cyc;
        ram_acc = (a != 16'hFFFF);
        lat = (rd && ram_acc) ? W : 1;
        for (int k = 0; k < reps; k++) begin
            if (rd) m_data = ram_acc ? ref_mem[a] : {6'b0, sw};
            else if (ram_acc) ref_mem[a] = d;
            else m_hex = d;
            m_count = m_count + 16'd1;
            e.data = m_data; e.hex = m_hex; e.count = m_count; e.addr = a;
            e.wdata = d;
            e.re_n = (rd && ram_acc) ? W : 0;
            e.we_n = (!rd && ram_acc) ? 1 : 0;
            e.due = n + k * (lat + 2) + lat;
            q.push_back(e);
        end
        repeat ((reps - 1) * (lat + 2)) @(posedge Clk);
        #1;
        Req_Rd = 0; Req_Wr = 0; ADDR = 16'($urandom); Data_from_CPU = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("drain_empty", 32'(q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i * 16'h9E37 + 16'h1357);
            ref_mem[i] = ram[i];
        end
        ram[16] = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_data", 32'(Data_to_CPU), 0);
        chk("rst_hex", 32'(Hex_Data), 0);
        chk("rst_count", 32'(Access_Count), 0);
        chk("rst_addr", 32'(RAM_addr), 0);
        chk("rst_wdata", 32'(RAM_wdata), 0);
        chk("rst_ready", 32'(Ready), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_re", 32'(RAM_re), 0);
        chk("rst_we", 32'(RAM_we), 0);
        #2 Reset = 0;

        do_access(1, 0, 16'h0010, 16'h0000, 10'h000, 1);
        do_access(0, 1, 16'h0020, 16'h1234, 10'h000, 1);
        do_access(0, 1, 16'hFFFF, 16'h00A5, 10'h000, 1);
        do_access(1, 0, 16'hFFFF, 16'h0000, 10'h3FF, 1);
        do_access(1, 1, 16'h0030, 16'h5555, 10'h000, 1);
        do_access(1, 0, 16'h0020, 16'h0000, 10'h000, 1);
        do_access(1, 0, 16'h0010, 16'h0000, 10'h000, 3);
        do_access(0, 1, 16'h0021, 16'h7777, 10'h000, 2);
        do_access(1, 0, 16'h0021, 16'h0000, 10'h000, 1);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 3);
            a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
            do_access(r != 2, r >= 2, a, 16'($urandom), 10'($urandom),
                      ($urandom_range(0, 7) == 0) ? 2 : 1);
        end
        drain();

        do_access(1, 0, 16'h0011, 16'h0000, 10'h000, 1);
        #1 Reset = 1;
        #1;
        chk("abort_re", 32'(RAM_re), 0);
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_ready", 32'(Ready), 0);
        chk("abort_count", 32'(Access_Count), 0);
        chk("abort_data", 32'(Data_to_CPU), 0);
        q.delete();
        m_data = '0; m_hex = '0; m_count = '0;
        re_seen = 0; we_seen = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #2 Reset = 0;
        repeat (6) @(negedge Clk);
        chk("post_abort_count", 32'(Access_Count), 0);
        chk("post_abort_busy", 32'(Busy), 0);
        do_access(1, 0, 16'h0012, 16'h0000, 10'h000, 1);
        drain();

        @(negedge Clk);
        force dut.access_count_q = 16'hFFFE;
        @(posedge Clk);
        #1 release dut.access_count_q;
        m_count = 16'hFFFE;
        do_access(0, 1, 16'h0005, 16'hCAFE, 10'h000, 1);
        do_access(1, 0, 16'h0005, 16'h0000, 10'h000, 1);
        do_access(1, 0, 16'hFFFF, 16'h0000, 10'h155, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slc3_mem_ctrl.md
SLC3_MEM_CTRL -- requirements
Module: slc3_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, RAM read latency in cycles; legal range 1..15.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req_Rd  input  1  CPU read request, level, sampled only in IDLE.
REQ-005 Req_Wr  input  1  CPU write request, level, sampled only in IDLE.
REQ-006 ADDR  input  16  CPU address (MAR).
REQ-007 Data_from_CPU  input  16  write data (MDR).
REQ-008 SW  input  10  board switches, memory-mapped at 0xFFFF.
REQ-009 Data_to_CPU  output  16  registered read data.
REQ-010 Ready  output  1  one-cycle completion pulse.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 RAM_addr  output  16  registered RAM address.
REQ-013 RAM_wdata  output  16  registered RAM write data.
REQ-014 RAM_re  output  1  RAM read enable.
REQ-015 RAM_we  output  1  RAM write enable.
REQ-016 RAM_rdata  input  16  RAM read data, valid WAIT_CYCLES cycles after RAM_re first asserted.
REQ-017 Hex_Data  output  16  memory-mapped hex display register.
REQ-018 Access_Count  output  16  count of completed accesses.

Function
REQ-019 States SHALL be IDLE, RD_WAIT, WR, IO, DONE.
REQ-020 IDLE: Req_Rd=1 -> latch ADDR into RAM_addr; ADDR=0xFFFF -> IO, else RD_WAIT with wait counter loaded to WAIT_CYCLES.
REQ-021 IDLE: Req_Wr=1 and Req_Rd=0 -> latch ADDR and Data_from_CPU; ADDR=0xFFFF -> IO, else WR.
REQ-022 Both requests high in IDLE SHALL be treated as a read; the write SHALL be dropped.
REQ-023 RD_WAIT: RAM_re=1 each cycle; counter decrements; on the cycle counter equals 1, Data_to_CPU <= RAM_rdata and next state is DONE.
REQ-024 Read timing: request sampled at edge N -> RAM_re high cycles N+1..N+WAIT_CYCLES -> Ready high cycle N+WAIT_CYCLES+1.
REQ-025 WR: RAM_we=1 for exactly one cycle (N+1), then DONE; Ready high cycle N+2.
REQ-026 IO read: Data_to_CPU <= {6'b0, SW}; IO write: Hex_Data <= latched data; RAM_re and RAM_we stay 0; DONE next; Ready high cycle N+2.
REQ-027 DONE: Ready=1 for one cycle; Access_Count increments by 1 modulo 2^16 (0xFFFF wraps to 0x0000); next state IDLE.
REQ-028 Requests in any non-IDLE state, including DONE, SHALL be ignored; a request still high on return to IDLE SHALL start a new access.
REQ-029 RAM_re and RAM_we SHALL never be high in the same cycle, and neither SHALL be high in IDLE, IO or DONE.
REQ-030 ADDR and Data_from_CPU changes after sampling SHALL NOT affect the access in progress.
REQ-031 Data_to_CPU SHALL hold its value until the next read completes; writes SHALL NOT modify it.

Reset
REQ-032 Reset=1 SHALL immediately, without a clock edge, force state IDLE and drive Data_to_CPU, Hex_Data, Access_Count, RAM_addr, RAM_wdata to 0x0000 and Ready, Busy, RAM_re, RAM_we to 0.
REQ-033 Reset asserted mid-access SHALL abort the access with no Ready pulse and no count increment.
REQ-034 First request after Reset deasserts SHALL be sampled on the first rising edge with Reset=0.

Verification
REQ-035 WAIT_CYCLES=2, Req_Rd with ADDR=0x0010, RAM_rdata=0xBEEF -> RAM_re high 2 cycles, RAM_addr=0x0010, Ready at N+3, Data_to_CPU=0xBEEF, Access_Count=1.
REQ-036 Req_Wr with ADDR=0x0020, data 0x1234 -> RAM_we high exactly cycle N+1 with RAM_addr=0x0020, RAM_wdata=0x1234; Ready at N+2.
REQ-037 ADDR=0xFFFF: write 0x00A5 -> Hex_Data=0x00A5, RAM_we never high; read with SW=0x3FF -> Data_to_CPU=0x03FF, RAM_re never high.
REQ-038 Req_Rd and Req_Wr both high, ADDR=0x0030 -> read performed, RAM_we never high, one Ready pulse.
REQ-039 Reset asserted during cycle 1 of RD_WAIT -> RAM_re drops same cycle, no Ready, Access_Count=0, Busy=0.
REQ-040 Access_Count preloaded to 0xFFFF via 65535 accesses, one more access -> Access_Count=0x0000.
